// File: rtl/sd_req_arbiter_if.sv
// sd_req_arbiter_if
//   Bundles the per-channel request side and the hps_io sd_rd/sd_wr/sd_ack
//   handshake of the SD request arbiter.
//   master : request/drive side (drive models, hps_io ack source)
//   slave  : the arbiter itself
//   Signals (NUM_CH channels, 32-bit LBA per channel):
//     req_rd, req_wr   one-cycle request pulses
//     req_lba          block address per channel, sampled with the request
//     mounted, protect image mounted / write protect per channel
//     sd_ack           hps_io ack per channel
//     sd_rd, sd_wr     hps_io strobes (one-hot or zero)
//     sd_lba           latched LBA per channel
//     busy, done, err  CPU-wait, completion pulse, error flag (with done)
//     active_ch        channel currently granted
interface sd_req_arbiter_if #(
    parameter int NUM_CH = 3,
    parameter int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic [NUM_CH-1:0]    req_rd;
    logic [NUM_CH-1:0]    req_wr;
    logic [32*NUM_CH-1:0] req_lba;
    logic [NUM_CH-1:0]    mounted;
    logic [NUM_CH-1:0]    protect;
    logic [NUM_CH-1:0]    sd_ack;
    logic [NUM_CH-1:0]    sd_rd;
    logic [NUM_CH-1:0]    sd_wr;
    logic [32*NUM_CH-1:0] sd_lba;
    logic [NUM_CH-1:0]    busy;
    logic [NUM_CH-1:0]    done;
    logic [NUM_CH-1:0]    err;
    logic [CW-1:0]        active_ch;

    modport master (
        output req_rd, req_wr, req_lba, mounted, protect, sd_ack,
        input  sd_rd, sd_wr, sd_lba, busy, done, err, active_ch
    );

    modport slave (
        input  req_rd, req_wr, req_lba, mounted, protect, sd_ack,
        output sd_rd, sd_wr, sd_lba, busy, done, err, active_ch
    );
endinterface

// File: rtl/sd_req_arbiter.sv
// sd_req_arbiter
//   Latches per-channel read/write requests from NUM_CH virtual drives and
//   serves them one at a time, round-robin, over the hps_io sd_rd/sd_wr/sd_ack
//   handshake. Unmounted channels and writes to protected channels complete
//   with an error and no SD strobe; an ack that never rises aborts after
//   TIMEOUT cycles (0 = wait forever).
//   Ports:
//     clk_sys  system clock
//     reset    asynchronous, active-high reset
//     bus      sd_req_arbiter_if.slave (requests, handshake, status)
module sd_req_arbiter #(
    parameter int          NUM_CH  = 3,
    parameter logic [23:0] TIMEOUT = 24'd14000000
) (
    input  logic             clk_sys,
    input  logic             reset,
    sd_req_arbiter_if.slave  bus
);
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_XFER  = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAIL  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_CH-1:0]    pend_q, pend_d;
    logic [NUM_CH-1:0]    op_q, op_d;
    logic [NUM_CH-1:0]    ack_old_q;
    logic [NUM_CH-1:0]    sd_rd_q, sd_rd_d;
    logic [NUM_CH-1:0]    sd_wr_q, sd_wr_d;
    logic [NUM_CH-1:0]    busy_q, busy_d;
    logic [NUM_CH-1:0]    done_q, done_d;
    logic [NUM_CH-1:0]    err_q, err_d;
    logic [32*NUM_CH-1:0] sd_lba_q, sd_lba_d;
    logic [CW-1:0]        ptr_q, ptr_d;
    logic [CW-1:0]        active_q, active_d;
    logic [23:0]          cnt_q, cnt_d;

    logic                 gnt_vld_s;
    logic [CW-1:0]        gnt_ch_s;
    logic [CW-1:0]        idx_s;
    logic [NUM_CH-1:0]    rej_s;
    logic [NUM_CH-1:0]    fin_s;
    logic [NUM_CH-1:0]    fail_s;
    logic                 cur_ack_s;
    logic                 cur_ack_old_s;

    // Round-robin pick: first pending channel at or after ptr, wrapping.
    always_comb begin
        gnt_vld_s = 1'b0;
        gnt_ch_s  = '0;
        idx_s     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx_s     = CW'((int'(ptr_q) + i) % NUM_CH);
            gnt_ch_s  = (pend_q[idx_s] && !gnt_vld_s) ? idx_s : gnt_ch_s;
            gnt_vld_s = gnt_vld_s | pend_q[idx_s];
        end
    end

    // Request latching, FSM next state and next values of the registered outputs.
    always_comb begin
        pend_d        = pend_q;
        op_d          = op_q;
        sd_lba_d      = sd_lba_q;
        state_d       = state_q;
        sd_rd_d       = sd_rd_q;
        sd_wr_d       = sd_wr_q;
        active_d      = active_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        rej_s         = '0;
        fin_s         = '0;
        fail_s        = '0;
        cur_ack_s     = bus.sd_ack[active_q];
        cur_ack_old_s = ack_old_q[active_q];

        // busy_q (not pend_q) gates acceptance so the done cycle stays closed.
        for (int i = 0; i < NUM_CH; i++) begin
            if ((bus.req_rd[i] || bus.req_wr[i]) && !busy_q[i]) begin
                if (bus.req_rd[i] && bus.req_wr[i]) begin
                    rej_s[i] = 1'b1;
                end else begin
                    pend_d[i]            = 1'b1;
                    op_d[i]              = bus.req_wr[i];
                    sd_lba_d[32*i +: 32] = bus.req_lba[32*i +: 32];
                end
            end else begin
                rej_s[i] = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (gnt_vld_s) begin
                    active_d = gnt_ch_s;
                    ptr_d    = (gnt_ch_s == CW'(NUM_CH - 1)) ? '0 : gnt_ch_s + CW'(1);
                    cnt_d    = 24'd0;
                    // Mount/protect only matter at grant time.
                    if (bus.mounted[gnt_ch_s] && !(op_q[gnt_ch_s] && bus.protect[gnt_ch_s])) begin
                        state_d           = ST_ISSUE;
                        sd_rd_d[gnt_ch_s] = ~op_q[gnt_ch_s];
                        sd_wr_d[gnt_ch_s] = op_q[gnt_ch_s];
                    end else begin
                        state_d = ST_FAIL;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (cur_ack_s && !cur_ack_old_s) begin
                    sd_rd_d = '0;
                    sd_wr_d = '0;
                    state_d = ST_XFER;
                end else if ((TIMEOUT != 24'd0) && (cnt_q == TIMEOUT - 24'd1)) begin
                    sd_rd_d = '0;
                    sd_wr_d = '0;
                    state_d = ST_FAIL;
                end else begin
                    cnt_d = (cnt_q == 24'hFF_FFFF) ? cnt_q : cnt_q + 24'd1;
                end
            end
            ST_XFER: begin
                if (!cur_ack_s && cur_ack_old_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_XFER;
                end
            end
            ST_DONE: begin
                fin_s[active_q]  = 1'b1;
                pend_d[active_q] = 1'b0;
                state_d          = ST_IDLE;
            end
            ST_FAIL: begin
                fin_s[active_q]  = 1'b1;
                fail_s[active_q] = 1'b1;
                pend_d[active_q] = 1'b0;
                state_d          = ST_IDLE;
            end
            default: begin
                sd_rd_d = '0;
                sd_wr_d = '0;
                state_d = ST_IDLE;
            end
        endcase

        // Rejected requests pulse done/err without ever raising busy.
        done_d = fin_s | rej_s;
        err_d  = fail_s | rej_s;
        busy_d = pend_d | fin_s;
    end

    // State and output registers.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pend_q    <= '0;
            op_q      <= '0;
            ack_old_q <= '0;
            sd_rd_q   <= '0;
            sd_wr_q   <= '0;
            busy_q    <= '0;
            done_q    <= '0;
            err_q     <= '0;
            sd_lba_q  <= '0;
            ptr_q     <= '0;
            active_q  <= '0;
            cnt_q     <= 24'd0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            op_q      <= op_d;
            ack_old_q <= bus.sd_ack;
            sd_rd_q   <= sd_rd_d;
            sd_wr_q   <= sd_wr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            sd_lba_q  <= sd_lba_d;
            ptr_q     <= ptr_d;
            active_q  <= active_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.sd_rd     = sd_rd_q;
    assign bus.sd_wr     = sd_wr_q;
    assign bus.sd_lba    = sd_lba_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.active_ch = active_q;
endmodule

// File: tb/tb_sd_req_arbiter.sv
// tb_sd_req_arbiter
//   Directed scenarios followed by random traffic; every cycle the DUT outputs
//   are compared against a transaction-level reference model of the arbiter.
module tb_sd_req_arbiter;
    localparam int          N  = 3;
    localparam logic [23:0] TO = 24'd16;

    // Service-slot phases of the reference model.
    localparam int PH_FREE   = 0;  // nothing granted
    localparam int PH_STROBE = 1;  // strobe up, waiting for ack to rise
    localparam int PH_ACKED  = 2;  // ack seen, waiting for it to fall
    localparam int PH_FINISH = 3;  // result goes out at the next edge

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    sd_req_arbiter_if #(.NUM_CH(N)) bus ();

    sd_req_arbiter #(.NUM_CH(N), .TIMEOUT(TO)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .bus     (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [N-1:0] m_pend, m_op, m_busy, m_done, m_err, m_rd, m_wr, m_prev_ack;
    logic [31:0]  m_lba [N];
    int           m_ptr, m_ch, m_phase, m_wait;
    logic         m_fail;

    // Ack responder.
    int           r_cnt, r_delay, r_len;
    bit           r_never, r_fixed;
    logic [N-1:0] ack_force;

    int           t4_hi, t6_done;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_op = '0; m_busy = '0; m_done = '0; m_err = '0;
        m_rd = '0; m_wr = '0; m_prev_ack = '0;
        for (int c = 0; c < N; c++) m_lba[c] = 32'd0;
        m_ptr = 0; m_ch = 0; m_phase = PH_FREE; m_wait = 0; m_fail = 1'b0;
    endtask

    // Advances the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        logic [N-1:0] fin, nd, ne, ack;
        int c;
        fin = '0; nd = '0; ne = '0;
        ack = bus.sd_ack;
        if (m_phase == PH_FINISH) begin
            fin[m_ch]    = 1'b1;
            nd[m_ch]     = 1'b1;
            ne[m_ch]     = m_fail;
            m_pend[m_ch] = 1'b0;
            m_phase      = PH_FREE;
        end else if (m_phase == PH_FREE) begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (m_phase == PH_FREE && m_pend[c]) begin
                    m_ch   = c;
                    m_ptr  = (c + 1) % N;
                    m_wait = 0;
                    if (bus.mounted[c] && !(m_op[c] && bus.protect[c])) begin
                        m_phase = PH_STROBE;
                        m_fail  = 1'b0;
                        m_rd[c] = !m_op[c];
                        m_wr[c] = m_op[c];
                    end else begin
                        m_phase = PH_FINISH;
                        m_fail  = 1'b1;
                    end
                end
            end
        end else if (m_phase == PH_STROBE) begin
            if (ack[m_ch] && !m_prev_ack[m_ch]) begin
                m_rd = '0; m_wr = '0; m_phase = PH_ACKED;
            end else if (m_wait == int'(TO) - 1) begin
                m_rd = '0; m_wr = '0; m_phase = PH_FINISH; m_fail = 1'b1;
            end else begin
                m_wait++;
            end
        end else begin
            if (!ack[m_ch] && m_prev_ack[m_ch]) begin
                m_phase = PH_FINISH;
                m_fail  = 1'b0;
            end
        end
        for (int k = 0; k < N; k++) begin
            if ((bus.req_rd[k] || bus.req_wr[k]) && !m_busy[k]) begin
                if (bus.req_rd[k] && bus.req_wr[k]) begin
                    nd[k] = 1'b1;
                    ne[k] = 1'b1;
                end else begin
                    m_pend[k] = 1'b1;
                    m_op[k]   = bus.req_wr[k];
                    m_lba[k]  = bus.req_lba[32*k +: 32];
                end
            end
        end
        m_busy     = m_pend | fin;
        m_done     = nd;
        m_err      = ne;
        m_prev_ack = ack;
    endtask

    // Plays hps_io: ack after r_delay strobe cycles, held r_len cycles; noise on other channels.
    task automatic drive_ack();
        logic [N-1:0] a;
        a = '0;
        if (m_phase == PH_STROBE || m_phase == PH_ACKED) begin
            for (int c = 0; c < N; c++)
                if (c != m_ch) a[c] = ($urandom_range(0, 3) == 0);
            if (m_phase == PH_STROBE) a[m_ch] = !r_never && (r_cnt >= r_delay);
            else                      a[m_ch] = (r_cnt < r_delay + r_len);
            r_cnt++;
        end else begin
            r_cnt = 0;
            if (!r_fixed) begin
                r_delay = $urandom_range(0, 4);
                r_len   = $urandom_range(1, 5);
                r_never = ($urandom_range(0, 5) == 0);
            end
        end
        bus.sd_ack = a | ack_force;
    endtask

    task automatic check_outputs();
        check_val("sd_rd", bus.sd_rd, m_rd);
        check_val("sd_wr", bus.sd_wr, m_wr);
        check_val("busy",  bus.busy,  m_busy);
        check_val("done",  bus.done,  m_done);
        check_val("err",   bus.err,   m_err);
        for (int c = 0; c < N; c++) check_val("sd_lba", bus.sd_lba[32*c +: 32], m_lba[c]);
        if (m_phase == PH_STROBE || m_phase == PH_ACKED) check_val("active_ch", bus.active_ch, m_ch);
    endtask

    task automatic cycle();
        drive_ack();
        @(posedge clk_sys);
        if (reset) model_reset();
        else       model_step();
        @(negedge clk_sys);
        check_outputs();
        bus.req_rd  = '0;
        bus.req_wr  = '0;
        bus.req_lba = {$urandom(), $urandom(), $urandom()};
    endtask

    task automatic wait_free(input int budget);
        int k;
        k = 0;
        while ((m_phase != PH_FREE || m_busy != '0) && k < budget) begin
            cycle();
            k++;
        end
        check_val("wait_free", (m_phase == PH_FREE && m_busy == '0), 1);
    endtask

    initial begin
        bus.req_rd = '0; bus.req_wr = '0; bus.req_lba = '0;
        bus.mounted = '1; bus.protect = '0; bus.sd_ack = '0;
        ack_force = '0; r_fixed = 1'b1; r_never = 1'b0; r_delay = 1; r_len = 2; r_cnt = 0;
        model_reset();

        // Reset state
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;

        // 1: ch1 read at LBA 0x123, ack held 5 cycles
        r_delay = 2; r_len = 5;
        bus.req_lba = {32'h0000_0000, 32'h0000_0123, 32'h0000_0000};
        bus.req_rd  = 3'b010;
        cycle();
        check_val("t1_busy", bus.busy, 3'b010);
        check_val("t1_lba", bus.sd_lba[63:32], 32'h0000_0123);
        cycle();
        check_val("t1_sd_rd", bus.sd_rd, 3'b010);
        wait_free(40);

        // 2: round-robin ordering from ptr=0 then ptr=1
        r_delay = 1; r_len = 2;
        bus.req_rd = 3'b100; cycle(); wait_free(40);
        bus.req_wr = 3'b001; bus.req_rd = 3'b100; cycle(); cycle();
        check_val("t2_first_ch0", bus.sd_wr, 3'b001);
        wait_free(80);
        bus.req_rd = 3'b001; cycle(); wait_free(40);
        bus.req_wr = 3'b001; bus.req_rd = 3'b100; cycle(); cycle();
        check_val("t2_first_ch2", bus.sd_rd, 3'b100);
        wait_free(80);

        // 3: unmounted read, protected write
        bus.mounted = 3'b101; bus.req_rd = 3'b010;
        cycle(); cycle(); cycle();
        check_val("t3_unmnt_done", bus.done, 3'b010);
        check_val("t3_unmnt_err", bus.err, 3'b010);
        wait_free(10);
        bus.mounted = '1; bus.protect = 3'b001; bus.req_wr = 3'b001;
        cycle(); cycle(); cycle();
        check_val("t3_prot_done", bus.done, 3'b001);
        check_val("t3_prot_err", bus.err, 3'b001);
        wait_free(10);
        bus.protect = '0;

        // 4: ack timeout on ch0, ch1 queued behind it
        r_never = 1'b1; t4_hi = 0;
        bus.req_rd = 3'b001;
        for (int k = 0; k < 30; k++) begin
            if (k == 2) bus.req_rd = 3'b010;
            cycle();
            if (bus.sd_rd[0]) t4_hi++;
        end
        check_val("t4_strobe_len", t4_hi, 16);
        r_never = 1'b0;
        wait_free(60);

        // 5: async reset during the transfer phase of ch2
        r_delay = 1; r_len = 8;
        bus.req_rd = 3'b100;
        cycle();
        for (int k = 0; k < 10 && m_phase != PH_ACKED; k++) cycle();
        cycle();
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        cycle();
        reset = 1'b0;
        ack_force = 3'b100; cycle(); cycle();
        ack_force = '0;     cycle(); cycle();
        r_len = 2;
        bus.req_rd = 3'b100; cycle();
        wait_free(40);

        // 6: repeat request on busy ch1, rd+wr collision on ch0
        bus.req_rd = 3'b010; cycle();
        bus.req_rd = 3'b011; bus.req_wr = 3'b001; cycle();
        check_val("t6_rej_done", bus.done, 3'b001);
        check_val("t6_rej_err", bus.err, 3'b001);
        check_val("t6_rej_busy", bus.busy[0], 1'b0);
        t6_done = 0;
        for (int k = 0; k < 30; k++) begin
            cycle();
            if (bus.done[1]) t6_done++;
        end
        check_val("t6_ch1_once", t6_done, 1);
        wait_free(40);

        // Random traffic
        r_fixed = 1'b0;
        for (int t = 0; t < 1500; t++) begin
            logic [N-1:0] rd, wr;
            int r;
            if (t % 64 == 0) begin
                bus.mounted = N'($urandom()) | N'($urandom());
                bus.protect = N'($urandom()) & N'($urandom());
            end
            rd = '0; wr = '0;
            for (int c = 0; c < N; c++) begin
                r = $urandom_range(0, 15);
                if (r == 0)      rd[c] = 1'b1;
                else if (r == 1) wr[c] = 1'b1;
                else if (r == 2) begin
                    rd[c] = 1'b1;
                    wr[c] = ($urandom_range(0, 3) == 0);
                end
            end
            bus.req_rd = rd;
            bus.req_wr = wr;
            cycle();
        end
        wait_free(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sd_req_arbiter.md
Name: sd_req_arbiter

Overview:
- Parametrised successor to the single-drive HDD request/ack handshake in the emu top level.
- Serves NUM_CH virtual drives (HDD, floppy-track loaders, future slots): latches per-channel read/write request pulses and arbitrates them round-robin onto the hps_io sd_rd/sd_wr/sd_ack handshake.
- Also generates per-channel CPU-wait (busy) and completion/error pulses.
- Adds mount gating, write-protect rejection and an ack timeout.

Parameters:
NUM_CH, 3, number of drive channels (1..8)
TIMEOUT, 24'd14000000, clk_sys cycles to wait for ack rise before aborting; 0 disables timeout
CW, $clog2(NUM_CH) (min 1), width of active_ch

Ports:
clk_sys  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_rd  in  NUM_CH  one-cycle read request pulse per channel
req_wr  in  NUM_CH  one-cycle write request pulse per channel
req_lba  in  32*NUM_CH  block address per channel; sampled with the request
mounted  in  NUM_CH  image mounted (img_size != 0) per channel
protect  in  NUM_CH  write protect per channel
sd_ack  in  NUM_CH  hps_io ack per channel
sd_rd  out  NUM_CH  hps_io read strobe
sd_wr  out  NUM_CH  hps_io write strobe
sd_lba  out  32*NUM_CH  latched LBA per channel to hps_io
busy  out  NUM_CH  request pending or in service (drives CPU_WAIT)
done  out  NUM_CH  one-cycle completion pulse
err  out  NUM_CH  valid only with done; 1 = request failed
active_ch  out  CW  channel currently granted (valid when any sd_rd/sd_wr/ack phase active)

Behaviour:
- Reset (async, active-high): all outputs 0, pending cleared, FSM IDLE, round-robin pointer 0, timeout counter 0.
- Per-channel latch:
  - on req_rd|req_wr with channel not busy: set pend, op (1 = write), and sd_lba[ch] <= req_lba[ch].
  - busy[ch] is high from the cycle after the request until the cycle after done.
  - Request on a busy channel: ignored; no state change.
  - req_rd and req_wr together on one channel: rejected. done+err pulse the next cycle; busy never set.
- Arbitration: in IDLE, choose the first pending channel scanning from ptr upward, modulo NUM_CH. On grant, ptr <= granted+1 mod NUM_CH.
- FSM:
  - IDLE -> ISSUE on a grant with mounted=1 and not (op=write & protect=1). sd_rd/sd_wr[ch] is driven high from the next cycle, active_ch <= ch.
  - IDLE -> FAIL if the granted channel is unmounted, or is a write with protect=1. No SD strobe.
  - ISSUE: on ack rising edge (registered old_ack=0, ack=1), drop sd_rd/sd_wr and go to XFER.
    - If TIMEOUT != 0 and the counter reaches TIMEOUT-1 without an ack rise, drop the strobe and go to FAIL.
  - XFER: on ack falling edge -> DONE. No timeout in XFER.
  - DONE: one cycle. done[ch]=1, err=0, clear pend -> IDLE.
  - FAIL: one cycle. done[ch]=1, err[ch]=1, clear pend -> IDLE.
- Latency:
  - req at edge E0 -> busy high after E0 -> sd_rd high after E1 (if the arbiter is idle).
  - Ack fall sampled at Ek -> done high after Ek+1 for exactly one cycle.
- mounted deasserted mid-transaction: ignored; the transaction completes normally. Only mounted at grant time matters.
- Timeout counter: clears on every grant; counts only in ISSUE; saturates, no wrap.
- Only one channel is ever in ISSUE/XFER; sd_rd/sd_wr are one-hot or zero.
- Ack on a non-granted channel: ignored.
- Request arriving on the same cycle as that channel's done: ignored (channel still busy). Software re-issues.

Test Plan:
1. Channel 1 read, LBA 0x00000123, mounted: pulse req_rd[1].
   -> busy[1]=1 next cycle; sd_rd=3'b010 one cycle later; sd_lba[1]=0x123.
   Ack high 5 cycles, then low -> sd_rd drops on ack rise; done[1]=1, err=0 one cycle after the fall is sampled; busy[1]=0 after.
2. req_wr[0] and req_rd[2] in the same cycle, ptr=0 -> ch0 served first (sd_wr=3'b001); after done, ch2 (sd_rd=3'b100); ptr ends at 0.
   Repeat with ptr=1 -> ch2 is served before ch0.
3. req_rd[1] with mounted[1]=0 -> no sd_rd ever; done[1]=err[1]=1 two cycles after the request.
   req_wr[0] with protect[0]=1 -> same error response.
4. TIMEOUT=16, req_rd[0], ack never asserted -> sd_rd[0] high exactly 16 cycles, then low; done[0]=err[0]=1; next pending channel then granted.
5. Assert reset while in XFER on ch2 -> all outputs 0 immediately (async). After release, ack transitions cause no done; a new req_rd[2] is served normally.
6. Second req_rd[1] while ch1 is busy, and req_rd|req_wr simultaneously on ch0:
   -> ch1 serviced once (one done).
   -> ch0 gives done+err next cycle, with no SD strobe.
